seq_divider: RTL and testbench

- Shared iterative unsigned divider that sits directly downstream of the speed calculation block.
- Consumes its dividend/divisor operands and produces the quotient plus busy/ready handshake that the speed block polls.
- Restoring shift-subtract algorithm, one quotient bit per clock.
- One instance serves the bike computer; arbitration between clients is outside this block.

---
 rtl/bike_pkg.sv | 14 +
 rtl/seq_divider_if.sv | 26 ++
 rtl/seq_divider.sv | 125 ++++++++++++
 tb/tb_seq_divider.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bike_pkg.sv
// Definitions shared by the bike-computer arithmetic blocks.
// Holds the divider FSM encoding and the default datapath width.
package bike_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ZERO = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result handshake between a divider client and seq_divider.
// The client (speed block) is the master and the divider is the slave.
interface seq_divider_if #(
  parameter int WIDTH = bike_pkg::DIV_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             ready;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, ready, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, ready, div_by_zero
  );

endinterface

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
// Starts on a rising edge of start; results are held while ready is high.
module seq_divider
  import bike_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus
);

  div_state_e       state_q, state_d;
  logic             start_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // partial remainder
  logic [WIDTH-1:0] dq_q, dq_d;     // dividend bits out at the top, quotient bits in at the bottom
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             dbz_q, dbz_d;

  logic             trigger;
  logic [WIDTH:0]   rem_tmp;
  logic             sub_ok;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] dq_next;

  assign trigger = bus.start & ~start_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    dq_d     = dq_q;
    dvs_d    = dvs_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    busy_d   = busy_q;
    ready_d  = ready_q;
    dbz_d    = dbz_q;

    rem_tmp  = {acc_q, dq_q[WIDTH-1]};
    sub_ok   = rem_tmp >= {1'b0, dvs_q};
    // When sub_ok the true difference is below the divisor, so WIDTH bits hold it exactly.
    acc_next = sub_ok ? (rem_tmp[WIDTH-1:0] - dvs_q) : rem_tmp[WIDTH-1:0];
    dq_next  = {dq_q[WIDTH-2:0], sub_ok};

    case (state_q)
      IDLE, DONE: begin
        if (trigger) begin
          dq_d    = bus.dividend;
          dvs_d   = bus.divisor;
          acc_d   = '0;
          cnt_d   = CNT_W'(WIDTH - 1);
          busy_d  = 1'b1;
          ready_d = 1'b0;
          dbz_d   = 1'b0;
          state_d = (bus.divisor == '0) ? ZERO : CALC;
        end
      end
      CALC: begin
        acc_d = acc_next;
        dq_d  = dq_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          quo_d   = dq_next;
          rem_d   = acc_next;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          state_d = DONE;
        end
      end
      ZERO: begin
        quo_d   = '1;
        rem_d   = dq_q;
        dbz_d   = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      dq_q    <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= bus.start;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dq_q    <= dq_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.busy        = busy_q;
  assign bus.ready       = ready_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: fixed vectors, random operands against
// an arithmetic reference, plus held-start and mid-operation reset sequences.
module tb_seq_divider;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: plain integer division, all-ones/dividend on divide by zero.
  task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r);
    if (b == 0) begin
      q = '1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Pulse start for one cycle, scramble operands afterwards, wait for ready.
  // lat counts edges from the trigger edge inclusive to the first ready sample.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom);
    lat      = 1;
    busy_cnt = 0;
    while (!bus.ready && lat < 100) begin
      busy_cnt += int'(bus.busy);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
    int lat, bc;
    run_op(a, b, lat, bc);
    check({tag, " latency"}, lat, edbz ? 2 : W + 1);
    check({tag, " busy cycles"}, bc, edbz ? 1 : W);
    check({tag, " quotient"}, bus.quotient, eq);
    check({tag, " remainder"}, bus.remainder, er);
    check({tag, " div_by_zero"}, bus.div_by_zero, edbz);
    check({tag, " busy at ready"}, bus.busy, 0);
  endtask

  initial begin
    vec_t vecs[9];
    int   lat, bc;
    logic [W-1:0] a, b, eq, er;

    vecs[0] = '{a: 16'd14745, b: 16'd300,   q: 16'd49,    r: 16'd45,   dbz: 1'b0};
    vecs[1] = '{a: 16'd65535, b: 16'd1,     q: 16'd65535, r: 16'd0,    dbz: 1'b0};
    vecs[2] = '{a: 16'd5,     b: 16'd7,     q: 16'd0,     r: 16'd5,    dbz: 1'b0};
    vecs[3] = '{a: 16'd1234,  b: 16'd0,     q: 16'hFFFF,  r: 16'd1234, dbz: 1'b1};
    vecs[4] = '{a: 16'd100,   b: 16'd10,    q: 16'd10,    r: 16'd0,    dbz: 1'b0};
    vecs[5] = '{a: 16'd0,     b: 16'd5,     q: 16'd0,     r: 16'd0,    dbz: 1'b0};
    vecs[6] = '{a: 16'd65535, b: 16'd65535, q: 16'd1,     r: 16'd0,    dbz: 1'b0};
    vecs[7] = '{a: 16'd1,     b: 16'd65535, q: 16'd0,     r: 16'd1,    dbz: 1'b0};
    vecs[8] = '{a: 16'd40000, b: 16'd123,   q: 16'd325,   r: 16'd25,   dbz: 1'b0};

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    check("reset busy", bus.busy, 0);
    check("reset ready", bus.ready, 0);
    check("reset quotient", bus.quotient, 0);
    check("reset remainder", bus.remainder, 0);
    check("reset div_by_zero", bus.div_by_zero, 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);

    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = W'($urandom_range(1, 15));
        default: b = W'($urandom);
      endcase
      ref_div(a, b, eq, er);
      check_op($sformatf("rand%0d", i), a, b, eq, er, b == 0);
    end

    // Start held high for 40 cycles with operands changed mid-way: exactly one operation.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'd14745;
    bus.divisor  = 16'd300;
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 2) begin
        bus.dividend = 16'd999;
        bus.divisor  = 16'd3;
      end
      bc += int'(bus.busy);
    end
    check("held busy cycles", bc, W);
    check("held ready", bus.ready, 1);
    check("held quotient", bus.quotient, 49);
    check("held remainder", bus.remainder, 45);

    // Release, then re-raise: new operation, ready falls as busy rises.
    @(negedge clk);
    bus.start = 1'b0;
    check("ready before retrigger", bus.ready, 1);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'd5000;
    bus.divisor  = 16'd50;
    @(negedge clk);
    check("retrigger busy", bus.busy, 1);
    check("retrigger ready", bus.ready, 0);
    lat = 1;
    while (!bus.ready && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("retrigger latency", lat, W + 1);
    check("retrigger quotient", bus.quotient, 100);
    check("retrigger remainder", bus.remainder, 0);
    bus.start = 1'b0;

    // Reset in the middle of a calculation discards it.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'd1000;
    bus.divisor  = 16'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    check("mid-op busy before reset", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid-op reset busy", bus.busy, 0);
    check("mid-op reset ready", bus.ready, 0);
    check("mid-op reset quotient", bus.quotient, 0);
    repeat (3) @(negedge clk);
    check("idle after reset busy", bus.busy, 0);
    check_op("post-reset", 16'd100, 16'd10, 16'd10, 16'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
